// File: rtl/edge_event_arbiter_if.sv
// Event port bundle: valid/ready handshake carrying a channel id and edge type.
// Ports: evt_valid, evt_ready, evt_ch[CH_W], evt_rise; master drives the event.
interface edge_event_arbiter_if #(
    parameter int CH_W = 2
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_rise;

    modport master (
        output evt_valid,
        output evt_ch,
        output evt_rise,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_rise,
        output evt_ready
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Edge-event collector: per-channel rise/fall capture into pending flags,
// round-robin serialisation onto one valid/ready event port.
// Ports: clk, rst (async high), sig_in/rise_en/fall_en[N_CH], evt (master),
//        ovf[N_CH] sticky coalesce flags, ovf_clr[N_CH], busy.
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        sig_in,
    input  logic [N_CH-1:0]        rise_en,
    input  logic [N_CH-1:0]        fall_en,
    edge_event_arbiter_if.master   evt,
    output logic [N_CH-1:0]        ovf,
    input  logic [N_CH-1:0]        ovf_clr,
    output logic                   busy
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t          state_q, state_d;
    logic [N_CH-1:0] sig_prev;
    logic [N_CH-1:0] rise_pend, fall_pend;
    logic [N_CH-1:0] rise_cap, fall_cap;
    logic [N_CH-1:0] pop_rise, pop_fall;
    logic [N_CH-1:0] ovf_q;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic            valid_q, valid_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic            rise_q, rise_d;
    logic            found;
    logic [CH_W-1:0] gnt_ch;
    logic            gnt_rise;
    logic [CH_W-1:0] idx;
    logic            grant;

    assign rise_cap = sig_in & ~sig_prev & rise_en;
    assign fall_cap = ~sig_in & sig_prev & fall_en;

    // Round-robin scan starting at ptr; rise wins over fall within a channel.
    always_comb begin
        found    = 1'b0;
        gnt_ch   = '0;
        gnt_rise = 1'b0;
        idx      = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = CH_W'((int'(ptr_q) + k) % N_CH);
            if (!found && (rise_pend[idx] || fall_pend[idx])) begin
                found    = 1'b1;
                gnt_ch   = idx;
                gnt_rise = rise_pend[idx];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        valid_d  = valid_q;
        ch_d     = ch_q;
        rise_d   = rise_q;
        ptr_d    = ptr_q;
        pop_rise = '0;
        pop_fall = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant   = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (evt.evt_ready) begin
                    if (found) begin
                        grant = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant) begin
            valid_d = 1'b1;
            ch_d    = gnt_ch;
            rise_d  = gnt_rise;
            ptr_d   = (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
            if (gnt_rise) begin
                pop_rise[gnt_ch] = 1'b1;
            end else begin
                pop_fall[gnt_ch] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sig_prev  <= '0;
            rise_pend <= '0;
            fall_pend <= '0;
            ovf_q     <= '0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            ch_q      <= '0;
            rise_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sig_prev  <= sig_in;
            // A capture in the same cycle as a pop keeps the flag set.
            rise_pend <= rise_cap | (rise_pend & ~pop_rise);
            fall_pend <= fall_cap | (fall_pend & ~pop_fall);
            // New coalesce beats a simultaneous clear.
            ovf_q     <= (rise_cap & rise_pend & ~pop_rise)
                       | (fall_cap & fall_pend & ~pop_fall)
                       | (ovf_q & ~ovf_clr);
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            ch_q      <= ch_d;
            rise_q    <= rise_d;
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_ch    = ch_q;
    assign evt.evt_rise  = rise_q;
    assign ovf           = ovf_q;
    assign busy          = (|rise_pend) | (|fall_pend) | valid_q;

endmodule
